// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, PRId value and
// SR/Cause field positions, plus the two-state exception FSM encoding.
package cp0_pkg;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_SR       = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;
    localparam logic [4:0] CP0_REG_PRID     = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [31:0] CP0_PRID_VALUE = 32'h0000_2004;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int SR_IM_MSB     = 15;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_EXC_MSB = 6;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_IP_MSB  = 15;
    localparam int CAUSE_BD_BIT  = 31;

    // The state value is SR.EXL itself.
    typedef enum logic {
        CP0_USER    = 1'b0,
        CP0_HANDLER = 1'b1
    } cp0_state_e;

endpackage

// File: rtl/exc_cp0.sv
// Coprocessor-0 exception unit: SR/Cause/EPC/PRId, interrupt/exception
// arbitration and eret. Optional BadVAddr register under CP0_BADVADDR_EN.
module exc_cp0
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  rd_addr,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] din,
    input  logic [31:0] pc_m,
    input  logic [4:0]  exc_m,
    input  logic        bd_m,
    input  logic        eret_m,
    input  logic [5:0]  hw_int,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0] badvaddr_m,
`endif
    output logic [31:0] dout,
    output logic [31:0] epc_out,
    output logic        req
);

    cp0_state_e  state_q, state_d;
    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;
`ifdef CP0_BADVADDR_EN
    logic [31:0] bva_q, bva_d;
`endif

    logic        sr_exl;
    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_aligned;
    logic [31:0] sr_rd;
    logic [31:0] cause_rd;

    assign sr_exl     = (state_q == CP0_HANDLER);
    assign int_req    = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl;
    assign exc_req    = (exc_m != EXC_INT) & ~sr_exl;
    assign req        = int_req | exc_req;
    assign pc_aligned = pc_m & ~32'd3;
    assign epc_out    = epc_q;

    always_comb begin
        state_d     = state_q;
        sr_im_d     = sr_im_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = hw_int;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
`ifdef CP0_BADVADDR_EN
        bva_d       = bva_q;
`endif
        if (req) begin
            // Taking the exception swallows any mtc0 or eret on this edge.
            state_d     = CP0_HANDLER;
            cause_bd_d  = bd_m;
            cause_exc_d = int_req ? EXC_INT : exc_m;
            epc_d       = bd_m ? (pc_aligned - 32'd4) : pc_aligned;
`ifdef CP0_BADVADDR_EN
            if (!int_req && (exc_m == EXC_ADEL || exc_m == EXC_ADES)) begin
                bva_d = badvaddr_m;
            end
`endif
        end else begin
            if (en) begin
                case (wr_addr)
                    CP0_REG_SR: begin
                        sr_im_d = din[SR_IM_MSB:SR_IM_LSB];
                        sr_ie_d = din[SR_IE_BIT];
                        state_d = cp0_state_e'(din[SR_EXL_BIT]);
                    end
                    CP0_REG_EPC: epc_d = din;
                    default: ;
                endcase
            end
            if (eret_m) begin
                state_d = CP0_USER;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CP0_USER;
            sr_im_q     <= '0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
`ifdef CP0_BADVADDR_EN
            bva_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sr_im_q     <= sr_im_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
`ifdef CP0_BADVADDR_EN
            bva_q       <= bva_d;
`endif
        end
    end

    always_comb begin
        sr_rd = '0;
        sr_rd[SR_IM_MSB:SR_IM_LSB] = sr_im_q;
        sr_rd[SR_EXL_BIT]          = sr_exl;
        sr_rd[SR_IE_BIT]           = sr_ie_q;

        cause_rd = '0;
        cause_rd[CAUSE_BD_BIT]                = cause_bd_q;
        cause_rd[CAUSE_IP_MSB:CAUSE_IP_LSB]   = cause_ip_q;
        cause_rd[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = cause_exc_q;

        case (rd_addr)
`ifdef CP0_BADVADDR_EN
            CP0_REG_BADVADDR: dout = bva_q;
`endif
            CP0_REG_SR:       dout = sr_rd;
            CP0_REG_CAUSE:    dout = cause_rd;
            CP0_REG_EPC:      dout = epc_q;
            CP0_REG_PRID:     dout = CP0_PRID_VALUE;
            default:          dout = '0;
        endcase
    end

endmodule

// File: tb/tb_exc_cp0.sv
// Bench for exc_cp0: directed scenarios plus random traffic, every cycle's
// {req, dout, epc_out} is predicted by a field-level model and queued.
`timescale 1ns/100ps
module tb_exc_cp0;

`ifdef CP0_BADVADDR_EN
    localparam bit BVA_EN = 1'b1;
`else
    localparam bit BVA_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, en, bd_m, eret_m;
    logic [4:0]  rd_addr, wr_addr, exc_m;
    logic [31:0] din, pc_m, badvaddr_m;
    logic [5:0]  hw_int;
    logic [31:0] dout, epc_out;
    logic        req;

    exc_cp0 dut (
        .clk(clk), .reset(reset), .en(en), .rd_addr(rd_addr), .wr_addr(wr_addr),
        .din(din), .pc_m(pc_m), .exc_m(exc_m), .bd_m(bd_m), .eret_m(eret_m),
        .hw_int(hw_int),
`ifdef CP0_BADVADDR_EN
        .badvaddr_m(badvaddr_m),
`endif
        .dout(dout), .epc_out(epc_out), .req(req)
    );

    always #10 clk = ~clk;

    // Architectural view of the registers, one variable per field.
    int unsigned m_im, m_exl, m_ie, m_bd, m_ip, m_code, m_epc, m_bva;

    logic [64:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic bit m_int();
        return ((hw_int & m_im) != 0) && m_ie != 0 && m_exl == 0;
    endfunction

    function automatic bit m_req();
        return m_int() || (exc_m != 0 && m_exl == 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return BVA_EN ? m_bva : 32'd0;
            5'd12:   return m_im * 1024 + m_exl * 2 + m_ie;
            5'd13:   return m_bd * 32'h8000_0000 + m_ip * 1024 + m_code * 4;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_2004;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic clear_in();
        reset = 0; en = 0; wr_addr = 0; din = 0; exc_m = 0; bd_m = 0;
        eret_m = 0; hw_int = 0; pc_m = 0; badvaddr_m = 0; rd_addr = 0;
    endtask

    // Inputs for the cycle are already applied; queue the expected outputs.
    task automatic sample(input string nm);
        #1;
        exp_q.push_back({m_req(), m_read(rd_addr), m_epc});
        name_q.push_back(nm);
    endtask

    task automatic peek(input string nm, input logic [4:0] a, input logic [31:0] want);
        logic [4:0] keep;
        keep = rd_addr;
        rd_addr = a;
        #1;
        chk(nm, dout, want);
        rd_addr = keep;
        #1;
    endtask

    task automatic tick();
        int unsigned n_im, n_exl, n_ie, n_bd, n_ip, n_code, n_epc, n_bva;
        bit take, irq;
        take = m_req(); irq = m_int();
        n_im = m_im; n_exl = m_exl; n_ie = m_ie; n_bd = m_bd;
        n_ip = hw_int; n_code = m_code; n_epc = m_epc; n_bva = m_bva;
        if (reset) begin
            n_im = 0; n_exl = 0; n_ie = 0; n_bd = 0; n_ip = 0; n_code = 0; n_epc = 0; n_bva = 0;
        end else if (take) begin
            n_exl  = 1;
            n_bd   = bd_m;
            n_code = irq ? 0 : exc_m;
            n_epc  = (pc_m / 4) * 4 - (bd_m ? 4 : 0);
            if (BVA_EN && !irq && (exc_m == 4 || exc_m == 5)) n_bva = badvaddr_m;
        end else begin
            if (en && wr_addr == 12) begin
                n_im = (din / 1024) % 64; n_exl = (din / 2) % 2; n_ie = din % 2;
            end
            if (en && wr_addr == 14) n_epc = din;
            if (eret_m) n_exl = 0;
        end
        @(posedge clk);
        m_im = n_im; m_exl = n_exl; m_ie = n_ie; m_bd = n_bd;
        m_ip = n_ip; m_code = n_code; m_epc = n_epc; m_bva = n_bva;
        #1;
    endtask

    initial begin : monitor
        logic [64:0] e;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if ({req, dout, epc_out} !== e) begin
                    errors++;
                    $display("FAIL %s: got req=%b dout=%h epc=%h want req=%b dout=%h epc=%h",
                             n, req, dout, epc_out, e[64], e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin : driver
        logic [4:0] wr_set[6];
        logic [4:0] exc_set[6];
        wr_set  = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        exc_set = '{5'd4, 5'd5, 5'd8, 5'd10, 5'd12, 5'd31};

        clear_in();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ip = 0; m_code = 0; m_epc = 0; m_bva = 0;

        clear_in(); rd_addr = 12; sample("reset_sr");
        chk("reset_req", {31'd0, req}, 32'd0);
        peek("reset_cause", 13, 32'd0);
        peek("reset_epc", 14, 32'd0);
        en = 1; wr_addr = 12; din = 32'h0000_0401;
        tick();

        // Interrupt taken in the same cycle it is pending.
        clear_in(); hw_int = 6'b000001; pc_m = 32'h0000_3010; rd_addr = 14;
        sample("int_take");
        chk("int_req_now", {31'd0, req}, 32'd1);
        tick();
        clear_in(); hw_int = 6'b000001; eret_m = 1; rd_addr = 14; sample("int_after");
        chk("int_epc", epc_out, 32'h0000_3010);
        peek("int_cause", 13, 32'h0000_0400);
        peek("int_sr", 12, 32'h0000_0403);
        chk("handler_masks_int", {31'd0, req}, 32'd0);
        tick();

        // After eret a held interrupt is taken straight away.
        clear_in(); hw_int = 6'b000001; rd_addr = 12; sample("eret_reint");
        chk("eret_reint_req", {31'd0, req}, 32'd1);
        peek("eret_sr", 12, 32'h0000_0401);
        tick();
        clear_in(); eret_m = 1; sample("eret2"); tick();

        // Exception in a delay slot, then a masked second exception.
        clear_in(); exc_m = 5'd12; bd_m = 1; pc_m = 32'h0000_3024; sample("ov_bd");
        chk("ov_req", {31'd0, req}, 32'd1);
        tick();
        clear_in(); exc_m = 5'd10; rd_addr = 13; sample("ri_masked");
        chk("ri_masked_req", {31'd0, req}, 32'd0);
        peek("ov_epc", 14, 32'h0000_3020);
        peek("ov_cause", 13, 32'h8000_0030);
        tick();
        clear_in(); eret_m = 1; sample("eret3"); tick();

        // Interrupt beats AdEL; BadVAddr only loads for the real AdEL.
        clear_in(); hw_int = 6'b000001; exc_m = 5'd4; badvaddr_m = 32'h3; pc_m = 32'h0000_3000;
        rd_addr = 8; sample("int_vs_adel");
        tick();
        clear_in(); eret_m = 1; rd_addr = 8; sample("int_vs_adel_after");
        peek("int_vs_adel_cause", 13, 32'h0000_0400);
        peek("int_vs_adel_bva", 8, 32'd0);
        tick();
        clear_in(); exc_m = 5'd4; badvaddr_m = 32'h3; pc_m = 32'h0000_3100; sample("adel"); tick();
        clear_in(); eret_m = 1; rd_addr = 8; sample("adel_after");
        peek("adel_bva", 8, BVA_EN ? 32'h3 : 32'd0);
        peek("adel_cause", 13, 32'h0000_0010);
        tick();

        // mtc0 behaviour.
        clear_in(); en = 1; wr_addr = 13; din = 32'hFFFF_FFFF; sample("wr_cause"); tick();
        clear_in(); rd_addr = 13; en = 1; wr_addr = 12; din = 32'hFFFF_FFFF; sample("wr_sr");
        peek("cause_not_writable", 13, 32'h0000_0010);
        tick();
        clear_in(); rd_addr = 12; sample("sr_readback");
        peek("sr_value", 12, 32'h0000_FC03);
        peek("prid", 15, 32'h0000_2004);
        tick();

        // Reset wins over a pending request and an mtc0 on the same edge.
        clear_in(); en = 1; wr_addr = 12; din = 32'h0000_0401; sample("arm"); tick();
        clear_in(); hw_int = 6'b000001; reset = 1; en = 1; wr_addr = 14; din = 32'hDEAD_BEEF;
        sample("reset_vs_req");
        chk("reset_vs_req_req", {31'd0, req}, 32'd1);
        tick();
        clear_in(); rd_addr = 12; sample("post_reset");
        chk("post_reset_req", {31'd0, req}, 32'd0);
        peek("post_reset_cause", 13, 32'd0);
        peek("post_reset_epc", 14, 32'd0);
        tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            clear_in();
            reset      = ($urandom_range(0, 49) == 0);
            en         = ($urandom_range(0, 3) == 0);
            wr_addr    = wr_set[$urandom_range(0, 5)];
            din        = $urandom();
            rd_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                     : wr_set[$urandom_range(0, 5)];
            pc_m       = $urandom();
            bd_m       = 1'($urandom_range(0, 1));
            exc_m      = ($urandom_range(0, 2) == 0) ? exc_set[$urandom_range(0, 5)] : 5'd0;
            eret_m     = ($urandom_range(0, 5) == 0);
            hw_int     = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            badvaddr_m = $urandom();
            sample("random");
            tick();
        end

        clear_in();
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_cp0.md
EXC_CP0 -- requirements
Module: exc_cp0

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 reset  input  1  synchronous, active-high reset; clock clk.
REQ-003 en  input  1  mtc0 write strobe from M stage.
REQ-004 rd_addr  input  5  mfc0 register number.
REQ-005 wr_addr  input  5  mtc0 register number.
REQ-006 din  input  32  mtc0 write data.
REQ-007 pc_m  input  32  PC of the instruction in M.
REQ-008 exc_m  input  5  pipelined exception code of the M instruction; 0 = none.
REQ-009 bd_m  input  1  M instruction sits in a branch delay slot.
REQ-010 eret_m  input  1  eret in M.
REQ-011 hw_int  input  6  external interrupt lines, level-sensitive.
REQ-012 badvaddr_m  input  32  faulting address; present only with CP0_BADVADDR_EN.
REQ-013 dout  output  32  mfc0 read data, combinational.
REQ-014 epc_out  output  32  current EPC, for the eret redirect.
REQ-015 req  output  1  flush and redirect request to every pipeline register, combinational.

Function
REQ-016 Two-state FSM SHALL be encoded by SR.EXL: USER (EXL=0) and HANDLER (EXL=1).
- USER -> HANDLER on a clock edge with req=1.
- HANDLER -> USER on a clock edge with eret_m=1.
REQ-017 int_req SHALL be |(hw_int & SR.IM) & SR.IE & !SR.EXL.
REQ-018 exc_req SHALL be (exc_m != 0) & !SR.EXL.
REQ-019 req SHALL equal int_req | exc_req, with zero latency.
REQ-020 When both are pending, the interrupt SHALL win: ExcCode is written as 0.
REQ-021 On an edge with req=1, the block SHALL in the same edge set EXL<=1, Cause.BD<=bd_m, and Cause.ExcCode<=(int_req ? 0 : exc_m).
REQ-022 On that same edge, EPC SHALL load {pc_m[31:2],2'b00} when bd_m=0, and ({pc_m[31:2],2'b00} - 4) when bd_m=1.
REQ-023 On an edge with req=1, any mtc0 write SHALL be discarded.
REQ-024 req SHALL take priority over eret_m on the same edge.
REQ-025 SR (reg 12): IM=[15:10], EXL=[1], IE=[0] are writable; all other bits read 0.
REQ-026 Cause (reg 13): BD=[31], IP=[15:10], ExcCode=[6:2]; Cause is not mtc0-writable.
REQ-027 Cause.IP SHALL register hw_int every cycle, including in HANDLER; it has 1-cycle latency.
REQ-028 EPC (reg 14) SHALL be fully writable by mtc0.
REQ-029 PRId (reg 15) SHALL be the read-only constant 32'h0000_2004.
REQ-030 An mtc0 write SHALL be visible on dout from the next cycle; there is no bypass.
REQ-031 Reads of unimplemented addresses SHALL return 0; writes to them SHALL be ignored.
REQ-032 epc_out SHALL always reflect the registered EPC.
REQ-033 A new exception while EXL=1 SHALL be masked (no nesting); the state stays HANDLER.

Reset
REQ-034 Reset SHALL clear SR, Cause, EPC and BadVAddr to 0.
- Consequence: req=0 and the FSM is in USER.
REQ-035 Reset asserted mid-handler SHALL override req, eret_m and en on that edge.

Configuration
REQ-036 With CP0_BADVADDR_EN defined, the block SHALL implement BadVAddr (reg 8), read-only.
- It loads badvaddr_m on a req edge only when exc_m is AdEL(4) or AdES(5) and int_req=0.
REQ-037 With CP0_BADVADDR_EN undefined:
- the badvaddr_m port is absent;
- reg 8 reads 0.

Structure
REQ-038 Package cp0_pkg SHALL hold:
- register numbers 8/12/13/14/15;
- ExcCode constants Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12;
- the PRId value;
- SR/Cause field bit positions.
REQ-039 The block SHALL be one module with no sub-module; the req arbitration is inline combinational logic.

Verification
REQ-040 Test: SR=32'h0000_0401 (IM[10]=1, IE=1), pulse hw_int=6'b000001, pc_m=32'h0000_3010, bd_m=0 -> req=1 same cycle; next cycle EPC=32'h3010, ExcCode=0, EXL=1.
REQ-041 Test: exc_m=12, bd_m=1, pc_m=32'h0000_3024 -> EPC=32'h3020, Cause.BD=1, ExcCode=12; a second exc_m=10 one cycle later -> req=0.
REQ-042 Test: in HANDLER assert eret_m -> next cycle EXL=0; held hw_int with IE=1 -> req=1 again on the following cycle.
REQ-043 Test: simultaneous interrupt and exc_m=4 with CP0_BADVADDR_EN, badvaddr_m=32'h0000_0003 -> ExcCode=0, BadVAddr unchanged; repeat with no interrupt -> BadVAddr=32'h3.
REQ-044 Test: en=1, wr_addr=13, din=32'hFFFF_FFFF -> Cause unchanged; wr_addr=12 -> SR=32'h0000_FC03 and read back next cycle; rd_addr=15 -> 32'h0000_2004.
REQ-045 Test: reset asserted in the same cycle as req=1 -> all registers 0 after the edge, req=0.
